// File: rtl/elevador_pkg.sv
// ---------------------------------------------------------------------------
// elevador_pkg
// Shared types and constants for the 3-floor elevator controller.
//   state_t      : controller states (IDLE, MOVE_UP, MOVE_DOWN, DOOR)
//   FLOOR0..2    : floor codes as driven on floor_code
//   DIR_UP/DOWN  : encoding of the retained travel direction
//   floorMask    : one-hot request mask for a floor code
//   reqAbove     : any request strictly above a floor
//   reqBelow     : any request strictly below a floor
// ---------------------------------------------------------------------------
package elevador_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  localparam logic [1:0] FLOOR0 = 2'b00;
  localparam logic [1:0] FLOOR1 = 2'b01;
  localparam logic [1:0] FLOOR2 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Floor code 11 is never a legal floor, so it maps to an empty mask.
  function automatic logic [2:0] floorMask(input logic [1:0] f);
    logic [2:0] m;
    m = 3'b000;
    case (f)
      FLOOR0:  m = 3'b001;
      FLOOR1:  m = 3'b010;
      FLOOR2:  m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic reqAbove(input logic [2:0] p, input logic [1:0] f);
    logic r;
    r = 1'b0;
    case (f)
      FLOOR0:  r = p[1] | p[2];
      FLOOR1:  r = p[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic reqBelow(input logic [2:0] p, input logic [1:0] f);
    logic r;
    r = 1'b0;
    case (f)
      FLOOR2:  r = p[1] | p[0];
      FLOOR1:  r = p[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elevador_ctrl_3p_blink_gen.sv
// ---------------------------------------------------------------------------
// blink_gen
// Divider that produces the flashing display-enable phase while the car
// moves. The phase toggles every BLINK_DIV cycles and restarts at 1 after
// a clear, so the first BLINK_DIV cycles of a trip show the display lit.
//   clock    : system clock
//   reset    : synchronous active-high reset
//   i_clear  : hold the divider in its start condition (car not moving)
//   o_phase  : current flash phase
// ---------------------------------------------------------------------------
module blink_gen #(
  parameter int BLINK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_phase
);

  localparam int CW = $clog2(BLINK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  // Clearing whenever the car is stopped makes every trip from IDLE start
  // with the same phase; staying un-cleared across floors keeps the flash
  // continuous through a multi-floor run.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/elevador_ctrl_3p.sv
// ---------------------------------------------------------------------------
// elevador_ctrl_3p
// Floor-sequencing controller for a 3-floor elevator. Latches floor calls,
// runs the motor and door, tracks the current floor, and feeds the floor
// code and blink enable to the downstream 7-segment display controller.
//   clock       : system clock, rising edge
//   reset       : synchronous active-high reset (car returns to floor 0)
//   call[2:0]   : floor call buttons, bit i = floor i
//   floor_code  : current floor 00/01/10
//   disp_en     : 1 when stopped, flashing while moving
//   motor_up    : car moving up
//   motor_down  : car moving down
//   door_open   : door open
//   pending     : latched outstanding calls
// ---------------------------------------------------------------------------
module elevador_ctrl_3p
  import elevador_pkg::*;
#(
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 6,
  parameter int BLINK_DIV  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] call,
  output logic [1:0] floor_code,
  output logic       disp_en,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic [2:0] pending
);

  localparam int MAX_TD = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int MAX_P  = (MAX_TD > BLINK_DIV) ? MAX_TD : BLINK_DIV;
  localparam int CW     = $clog2(MAX_P) + 1;

  // Timers count down to zero, so loading N-1 holds a state for N cycles.
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYC - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYC - 1);

  state_t        r_state;
  logic [1:0]    r_floor;
  logic [2:0]    r_pending;
  logic          r_dir;
  logic [CW-1:0] r_travelCnt;
  logic [CW-1:0] r_doorCnt;

  logic [2:0]    w_pendSet;
  logic [1:0]    w_floorUp;
  logic [1:0]    w_floorDown;
  logic [2:0]    w_curMask;
  logic          w_moving;
  logic          w_blinkPhase;

  // Arrival decisions must see a call landing on the same edge, so the
  // moving states work from the pending set merged with the live buttons.
  assign w_pendSet   = r_pending | call;
  assign w_floorUp   = r_floor + 2'd1;
  assign w_floorDown = r_floor - 2'd1;
  assign w_curMask   = floorMask(r_floor);
  assign w_moving    = (r_state == MOVE_UP) || (r_state == MOVE_DOWN);

  // Main controller. IDLE decides on the registered pending set only,
  // giving one cycle of call-to-motion latency. Clearing the served floor
  // is applied after merging new calls so a simultaneous call loses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_floor     <= FLOOR0;
      r_pending   <= 3'b000;
      r_dir       <= DIR_UP;
      r_travelCnt <= '0;
      r_doorCnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pending <= w_pendSet;
          if ((r_pending & w_curMask) != 3'b000) begin
            r_state   <= DOOR;
            r_doorCnt <= DOOR_LOAD;
            r_pending <= w_pendSet & ~w_curMask;
          end else if ((r_dir == DIR_UP) && reqAbove(r_pending, r_floor)) begin
            r_state     <= MOVE_UP;
            r_travelCnt <= TRAVEL_LOAD;
          end else if ((r_dir == DIR_DOWN) && reqBelow(r_pending, r_floor)) begin
            r_state     <= MOVE_DOWN;
            r_travelCnt <= TRAVEL_LOAD;
          end else if (reqAbove(r_pending, r_floor)) begin
            r_state     <= MOVE_UP;
            r_dir       <= DIR_UP;
            r_travelCnt <= TRAVEL_LOAD;
          end else if (reqBelow(r_pending, r_floor)) begin
            r_state     <= MOVE_DOWN;
            r_dir       <= DIR_DOWN;
            r_travelCnt <= TRAVEL_LOAD;
          end
        end

        MOVE_UP: begin
          r_pending <= w_pendSet;
          if (r_travelCnt == '0) begin
            r_floor <= w_floorUp;
            if ((w_pendSet & floorMask(w_floorUp)) != 3'b000) begin
              r_state   <= DOOR;
              r_doorCnt <= DOOR_LOAD;
              r_pending <= w_pendSet & ~floorMask(w_floorUp);
            end else if (reqAbove(w_pendSet, w_floorUp)) begin
              r_travelCnt <= TRAVEL_LOAD;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_travelCnt <= r_travelCnt - CW'(1);
          end
        end

        MOVE_DOWN: begin
          r_pending <= w_pendSet;
          if (r_travelCnt == '0) begin
            r_floor <= w_floorDown;
            if ((w_pendSet & floorMask(w_floorDown)) != 3'b000) begin
              r_state   <= DOOR;
              r_doorCnt <= DOOR_LOAD;
              r_pending <= w_pendSet & ~floorMask(w_floorDown);
            end else if (reqBelow(w_pendSet, w_floorDown)) begin
              r_travelCnt <= TRAVEL_LOAD;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_travelCnt <= r_travelCnt - CW'(1);
          end
        end

        DOOR: begin
          // A call for the open floor only keeps the door open longer.
          r_pending <= r_pending | (call & ~w_curMask);
          if ((call & w_curMask) != 3'b000) begin
            r_doorCnt <= DOOR_LOAD;
          end else if (r_doorCnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_doorCnt <= r_doorCnt - CW'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  blink_gen #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clock   (clock),
    .reset   (reset),
    .i_clear (~w_moving),
    .o_phase (w_blinkPhase)
  );

  assign floor_code = r_floor;
  assign pending    = r_pending;
  assign motor_up   = (r_state == MOVE_UP);
  assign motor_down = (r_state == MOVE_DOWN);
  assign door_open  = (r_state == DOOR);
  assign disp_en    = w_moving ? w_blinkPhase : 1'b1;

endmodule

// File: tb/tb_elevador_ctrl_3p.sv
// ---------------------------------------------------------------------------
// tb_elevador_ctrl_3p
// Directed bench for the 3-floor elevator controller. A behavioural model
// tracks the car as a position, remaining travel/door time and trip age,
// and every cycle's outputs are compared against it; directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_elevador_ctrl_3p;

  localparam int TRAVEL_CYC = 8;
  localparam int DOOR_CYC   = 6;
  localparam int BLINK_DIV  = 2;

  logic       clock;
  logic       reset;
  logic [2:0] call;
  logic [1:0] floor_code;
  logic       disp_en;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic [2:0] pending;

  int total = 0;
  int bad   = 0;

  elevador_ctrl_3p #(
    .TRAVEL_CYC (TRAVEL_CYC),
    .DOOR_CYC   (DOOR_CYC),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .call       (call),
    .floor_code (floor_code),
    .disp_en    (disp_en),
    .motor_up   (motor_up),
    .motor_down (motor_down),
    .door_open  (door_open),
    .pending    (pending)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model of the car: floor index, motion (+1 up, -1 down, 0 stopped),
  // cycles spent on the current floor segment, door cycles left, cycles
  // since the trip began, retained direction and outstanding calls.
  int         mFloor    = 0;
  int         mMove     = 0;
  int         mTravel   = 0;
  int         mDoorLeft = 0;
  int         mAge      = 0;
  int         mDir      = 1;
  logic [2:0] mPend     = 3'b000;
  bit         modelValid = 1'b0;

  function automatic bit anyAbove(input logic [2:0] p, input int f);
    for (int i = f + 1; i < 3; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit anyBelow(input logic [2:0] p, input int f);
    for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model at each rising edge from the buttons seen there.
  always @(posedge clock) begin : modelStep
    int f, mv, tr, dl, age, dir;
    logic [2:0] p, old, curBit;
    if (reset) begin
      f = 0; mv = 0; tr = 0; dl = 0; age = 0; dir = 1; p = 3'b000;
    end else begin
      f = mFloor; mv = mMove; tr = mTravel; dl = mDoorLeft;
      age = mAge; dir = mDir; old = mPend;
      curBit = 3'b001 << f;
      if (dl > 0) begin
        p = old | (call & ~curBit);
        if (call[f]) dl = DOOR_CYC;
        else         dl = dl - 1;
      end else if (mv == 0) begin
        p = old | call;
        if (old[f]) begin
          dl   = DOOR_CYC;
          p[f] = 1'b0;
        end else if (dir == 1 && anyAbove(old, f)) begin
          mv = 1; tr = 0; age = 0;
        end else if (dir == -1 && anyBelow(old, f)) begin
          mv = -1; tr = 0; age = 0;
        end else if (anyAbove(old, f)) begin
          mv = 1; dir = 1; tr = 0; age = 0;
        end else if (anyBelow(old, f)) begin
          mv = -1; dir = -1; tr = 0; age = 0;
        end
      end else begin
        p   = old | call;
        tr  = tr + 1;
        age = age + 1;
        if (tr == TRAVEL_CYC) begin
          f  = f + mv;
          tr = 0;
          if (p[f]) begin
            p[f] = 1'b0;
            mv   = 0;
            dl   = DOOR_CYC;
          end else if (!((mv == 1) ? anyAbove(p, f) : anyBelow(p, f))) begin
            mv = 0;
          end
        end
      end
    end
    mFloor    <= f;
    mMove     <= mv;
    mTravel   <= tr;
    mDoorLeft <= dl;
    mAge      <= age;
    mDir      <= dir;
    mPend     <= p;
    if (reset) modelValid <= 1'b1;
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clock) begin
    if (modelValid) begin
      checkOutput("m_floor",  int'(floor_code), mFloor);
      checkOutput("m_up",     int'(motor_up),   int'(mMove == 1));
      checkOutput("m_down",   int'(motor_down), int'(mMove == -1));
      checkOutput("m_door",   int'(door_open),  int'(mDoorLeft > 0));
      checkOutput("m_pend",   int'(pending),    int'(mPend));
      checkOutput("m_disp",   int'(disp_en),
                  (mMove == 0) ? 1 : int'(((mAge / BLINK_DIV) % 2) == 0));
    end
  end

  // Drive a one-cycle button pulse; returns on the falling edge after the
  // rising edge that sampled it.
  task automatic applyStimulus(input logic [2:0] c);
    call = c;
    @(negedge clock);
    call = 3'b000;
  endtask

  // Count consecutive door-open cycles from the current falling edge.
  task automatic countDoor(output int n, output bit motorSeen);
    n = 0;
    motorSeen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!door_open) break;
      n++;
      if (motor_up || motor_down) motorSeen = 1'b1;
      @(negedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, cnt;
    bit ms;
    logic [3:0] pat;
    logic [1:0] f9;

    reset = 1'b1;
    call  = 3'b000;

    // Reset state
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkOutput("t1_floor", int'(floor_code), 0);
    checkOutput("t1_disp",  int'(disp_en), 1);
    checkOutput("t1_up",    int'(motor_up), 0);
    checkOutput("t1_down",  int'(motor_down), 0);
    checkOutput("t1_door",  int'(door_open), 0);
    checkOutput("t1_pend",  int'(pending), 0);

    // Floor 0 to floor 2 in one run
    applyStimulus(3'b100);
    checkOutput("t2_pend_latched", int'(pending), 4);
    cnt = 0; pat = 4'b0000; f9 = 2'b11;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (motor_up) begin
        cnt++;
        if (cnt <= 4) pat = {pat[2:0], disp_en};
        if (cnt == 9) f9 = floor_code;
      end else if (cnt > 0) begin
        break;
      end
    end
    checkOutput("t2_up_cycles",  cnt, 16);
    checkOutput("t2_blink",      int'(pat), 4'b1100);
    checkOutput("t2_floor_mid",  int'(f9), 1);
    checkOutput("t2_floor_end",  int'(floor_code), 2);
    checkOutput("t2_door_start", int'(door_open), 1);
    checkOutput("t2_pend_clear", int'(pending), 0);
    countDoor(n, ms);
    checkOutput("t2_door_cycles", n, 6);
    checkOutput("t2_idle_disp",   int'(disp_en), 1);

    // Back to floor 0 via reset, then a call for the current floor
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    checkOutput("t3_floor_reset", int'(floor_code), 0);
    applyStimulus(3'b001);
    checkOutput("t3_pend", int'(pending), 1);
    @(negedge clock);
    checkOutput("t3_door_now", int'(door_open), 1);
    checkOutput("t3_pend_clear", int'(pending), 0);
    countDoor(n, ms);
    checkOutput("t3_door_cycles", n, 6);
    checkOutput("t3_no_motor", int'(ms), 0);

    // Pass floor 1, serve floor 2, then return for a call left at floor 0
    applyStimulus(3'b100);
    cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (motor_up) cnt++;
    end
    applyStimulus(3'b001);
    checkOutput("t4_pend_both", int'(pending), 5);
    if (motor_up) cnt++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (motor_up) cnt++;
      else break;
    end
    checkOutput("t4_up_cycles", cnt, 16);
    checkOutput("t4_floor2",    int'(floor_code), 2);
    checkOutput("t4_pend_left", int'(pending), 1);
    countDoor(n, ms);
    checkOutput("t4_door2_cycles", n, 6);
    checkOutput("t4_idle_gap_down", int'(motor_down), 0);
    checkOutput("t4_idle_gap_door", int'(door_open), 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (motor_down) cnt++;
      else break;
    end
    checkOutput("t4_down_cycles", cnt, 16);
    checkOutput("t4_floor0",      int'(floor_code), 0);
    checkOutput("t4_door0",       int'(door_open), 1);
    checkOutput("t4_pend_empty",  int'(pending), 0);
    countDoor(n, ms);
    checkOutput("t4_door0_cycles", n, 6);

    // Door at floor 1 extended by a call for floor 1
    applyStimulus(3'b010);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (door_open) break;
    end
    checkOutput("t5_floor1", int'(floor_code), 1);
    repeat (2) @(negedge clock);
    applyStimulus(3'b010);
    checkOutput("t5_pend_stays0", int'(pending), 0);
    countDoor(n, ms);
    checkOutput("t5_door_total", 3 + n, 9);

    // Reset in the middle of a trip
    applyStimulus(3'b100);
    @(negedge clock);
    checkOutput("t6_moving", int'(motor_up), 1);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("t6_up_off", int'(motor_up), 0);
    checkOutput("t6_floor",  int'(floor_code), 0);
    checkOutput("t6_pend",   int'(pending), 0);
    checkOutput("t6_disp",   int'(disp_en), 1);
    @(negedge clock);
    checkOutput("t6_still_idle", int'(motor_up | motor_down | door_open), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
